// File: rtl/sram_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_sched                                                      |
// | Purpose  : Owns the external 8-bit-used SRAM. After reset it fills the     |
// |            array (ROM image into the low locations, zero elsewhere), then  |
// |            arbitrates single-byte accesses between the CPU port and the    |
// |            DMA port, with a starvation guard that forces DMA after STARVE  |
// |            consecutive CPU grants taken while DMA was waiting.             |
// | Ports    : clock/reset      - clock, asynchronous active-low reset         |
// |            romA/romQ        - synchronous ROM (1-clock read latency)       |
// |            init             - fill complete                                |
// |            cpuRd/cpuWr/cpuA/cpuD/cpuQ/cpuRdy - CPU request port            |
// |            dmaReq/dmaWe/dmaA/dmaD/dmaQ/dmaAck - DMA request port           |
// |            sramA/sramDQ/sramWe/sramOe/sramUb/sramLb - SRAM pins            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_sched #(
  parameter int AW     = 19,
  parameter int ROMN   = 65536,
  parameter int STARVE = 2
) (
  input  logic          clock,
  input  logic          reset,
  output logic [15:0]   romA,
  input  logic [7:0]    romQ,
  output logic          init,
  input  logic          cpuRd,
  input  logic          cpuWr,
  input  logic [AW-1:0] cpuA,
  input  logic [7:0]    cpuD,
  output logic [7:0]    cpuQ,
  output logic          cpuRdy,
  input  logic          dmaReq,
  input  logic          dmaWe,
  input  logic [AW-1:0] dmaA,
  input  logic [7:0]    dmaD,
  output logic [7:0]    dmaQ,
  output logic          dmaAck,
  output logic [20:0]   sramA,
  inout  wire  [15:0]   sramDQ,
  output logic          sramWe,
  output logic          sramOe,
  output logic          sramUb,
  output logic          sramLb
);

  localparam int              SW       = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0]   C_STARVE = SW'(STARVE);
  localparam logic [32:0]     C_ROMN   = 33'(ROMN);

  localparam logic [2:0] S_FILL_A = 3'd0;
  localparam logic [2:0] S_FILL_W = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACC    = 3'd3;
  localparam logic [2:0] S_STB    = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          init_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [7:0]    wd_q;
  logic          dma_q;      // current access belongs to the DMA port
  logic [SW-1:0] starve_q;
  logic [7:0]    cpu_rdata_q;
  logic [7:0]    dma_rdata_q;

  logic          w_cpu_pend;
  logic          w_dma_pend;
  logic          w_any_req;
  logic          w_grant_dma;
  logic          w_fill_last;
  logic          w_dq_oe;
  logic [7:0]    w_dq_out;
  logic [AW-1:0] w_addr;

  // A simultaneous read and write from the CPU is taken as a write.
  assign w_cpu_pend  = cpuRd | cpuWr;
  assign w_dma_pend  = dmaReq;
  assign w_any_req   = w_cpu_pend | w_dma_pend;
  // DMA wins when alone, or when the CPU has been favoured STARVE times in a row.
  assign w_grant_dma = w_dma_pend & (~w_cpu_pend | (starve_q == C_STARVE));
  assign w_fill_last = (cnt_q == {AW{1'b1}});

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FILL_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL_A: state_d = S_FILL_W;
      S_FILL_W: state_d = w_fill_last ? S_IDLE : S_FILL_A;
      S_IDLE:   if (w_any_req) state_d = S_ACC;
      S_ACC:    state_d = S_STB;
      S_STB:    state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_FILL_A;
    endcase
  end

  // Datapath registers: fill counter, grant latch, starve count, read data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      init_q      <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wd_q        <= 8'h00;
      dma_q       <= 1'b0;
      starve_q    <= '0;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
    end else begin
      if (state_q == S_FILL_W) begin
        cnt_q <= cnt_q + {{(AW-1){1'b0}}, 1'b1};
        if (w_fill_last) begin
          init_q <= 1'b1;
        end
      end

      if ((state_q == S_IDLE) && w_any_req) begin
        dma_q <= w_grant_dma;
        if (w_grant_dma) begin
          addr_q   <= dmaA;
          we_q     <= dmaWe;
          wd_q     <= dmaD;
          starve_q <= '0;
        end else begin
          addr_q <= cpuA;
          we_q   <= cpuWr;
          wd_q   <= cpuD;
          if (w_dma_pend) begin
            starve_q <= starve_q + SW'(1);
          end
        end
      end

      // Read data is sampled on the STB->ACK edge, after a full clock of OE low.
      if ((state_q == S_STB) && !we_q) begin
        if (dma_q) begin
          dma_rdata_q <= sramDQ[7:0];
        end else begin
          cpu_rdata_q <= sramDQ[7:0];
        end
      end
    end
  end

  // Output logic
  always_comb begin
    sramWe   = 1'b1;
    sramOe   = 1'b1;
    w_dq_oe  = 1'b0;
    w_dq_out = wd_q;
    cpuRdy   = 1'b0;
    dmaAck   = 1'b0;
    w_addr   = addr_q;
    case (state_q)
      S_FILL_A: begin
        w_addr = cnt_q;
      end
      S_FILL_W: begin
        w_addr   = cnt_q;
        sramWe   = 1'b0;
        w_dq_oe  = 1'b1;
        w_dq_out = (33'(cnt_q) < C_ROMN) ? romQ : 8'h00;
      end
      S_ACC: begin
        sramOe  = we_q;
        w_dq_oe = we_q;
      end
      S_STB: begin
        sramOe  = we_q;
        sramWe  = ~we_q;
        w_dq_oe = we_q;
      end
      S_ACK: begin
        // Write data stays on the bus one clock past the WE rising edge for hold.
        w_dq_oe = we_q;
        cpuRdy  = ~dma_q;
        dmaAck  = dma_q;
      end
      default: begin
      end
    endcase
  end

  assign romA   = 16'(cnt_q);
  assign sramA  = 21'(w_addr);
  assign sramDQ = w_dq_oe ? {2{w_dq_out}} : 16'hzzzz;
  assign sramUb = 1'b1;
  assign sramLb = 1'b0;
  assign init   = init_q;
  assign cpuQ   = cpu_rdata_q;
  assign dmaQ   = dma_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_sched                                                   |
// | Purpose  : Self-checking bench for sram_sched with a behavioural SRAM,     |
// |            ROM and expected-memory model.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_sched;

  localparam int AW     = 6;
  localparam int ROMN   = 16;
  localparam int STARVE = 2;
  localparam int DEPTH  = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   romA;
  logic [7:0]    romQ = 8'h00;
  logic          init;
  logic          cpuRd = 1'b0, cpuWr = 1'b0;
  logic [AW-1:0] cpuA = '0;
  logic [7:0]    cpuD = 8'h00;
  logic [7:0]    cpuQ;
  logic          cpuRdy;
  logic          dmaReq = 1'b0, dmaWe = 1'b0;
  logic [AW-1:0] dmaA = '0;
  logic [7:0]    dmaD = 8'h00;
  logic [7:0]    dmaQ;
  logic          dmaAck;
  logic [20:0]   sramA;
  wire  [15:0]   sramDQ;
  logic          sramWe, sramOe, sramUb, sramLb;

  int checks   = 0;
  int failures = 0;
  int we_low   = 0;

  logic [7:0] sram    [DEPTH];
  logic [7:0] exp_mem [DEPTH];

  sram_sched #(.AW(AW), .ROMN(ROMN), .STARVE(STARVE)) dut (
    .clock(clock), .reset(reset), .romA(romA), .romQ(romQ), .init(init),
    .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuRdy(cpuRdy),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaA(dmaA), .dmaD(dmaD), .dmaQ(dmaQ), .dmaAck(dmaAck),
    .sramA(sramA), .sramDQ(sramDQ), .sramWe(sramWe), .sramOe(sramOe),
    .sramUb(sramUb), .sramLb(sramLb)
  );

  always #5 clock = ~clock;

  // ROM: contents i + 8'h40, one clock of latency.
  always @(posedge clock) romQ <= 8'(romA + 16'h0040);

  // SRAM: writes land mid-cycle while WE is low; reads drive when OE low, WE high.
  always @(negedge clock) begin
    if (sramWe === 1'b0) begin
      sram[sramA[AW-1:0]] <= sramDQ[7:0];
      we_low <= we_low + 1;
    end
  end
  assign sramDQ = (sramOe === 1'b0 && sramWe === 1'b1) ? {8'h00, sram[sramA[AW-1:0]]} : 16'hzzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < ROMN) ? 8'(8'h40 + i) : 8'h00;
  endtask

  // Waits for init; n counts clock edges from reset release.
  task automatic wait_init(input int start, output int n, output bit early_rdy);
    n = start;
    early_rdy = 1'b0;
    while (init !== 1'b1 && n < 400) begin
      @(posedge clock); #1;
      n++;
      if (init !== 1'b1 && (cpuRdy === 1'b1 || dmaAck === 1'b1)) early_rdy = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sramWe"}, 32'(sramWe), 32'd1);
    chk({tag, "_dqz"}, {16'h0, sramDQ}, {16'h0, 16'hzzzz});
    chk({tag, "_init"}, 32'(init), 32'd0);
    chk({tag, "_sramA"}, 32'(sramA), 32'd0);
  endtask

  // One access on one port; called at posedge+1 with the DUT in IDLE.
  task automatic do_access(input bit dma, input bit we, input logic [AW-1:0] a,
                           input logic [7:0] d, output logic [7:0] q,
                           output int lat, output int wl);
    int w0;
    w0 = we_low;
    if (dma) begin
      dmaReq = 1'b1; dmaWe = we; dmaA = a; dmaD = d;
    end else begin
      cpuRd = !we; cpuWr = we; cpuA = a; cpuD = d;
    end
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!((dma ? dmaAck : cpuRdy) === 1'b1) && lat < 20);
    dmaReq = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0;
    q = dma ? dmaQ : cpuQ;
    @(posedge clock); #1;
    wl = we_low - w0;
    chk("dq_z_idle", {16'h0, sramDQ}, {16'h0, 16'hzzzz});
  endtask

  typedef struct {
    bit            dma;
    bit            we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    exp_q;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n, lat, wl, t_c, t_d, last_d, sc;
    bit early;
    logic [7:0] q, last_cpu_q, last_dma_q;
    bit exp_ord [6];
    bit got_ord [$];
    int got_t [$];

    tbl[0]  = '{1'b0, 1'b1, 6'd5,  8'hA5, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 6'd5,  8'h00, 8'hA5};
    tbl[2]  = '{1'b1, 1'b0, 6'd5,  8'h00, 8'hA5};
    tbl[3]  = '{1'b1, 1'b1, 6'd10, 8'h3C, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 6'd10, 8'h00, 8'h3C};
    tbl[5]  = '{1'b0, 1'b0, 6'd3,  8'h00, 8'h43};
    tbl[6]  = '{1'b1, 1'b0, 6'd40, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 6'd63, 8'hFF, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 6'd63, 8'h00, 8'hFF};
    tbl[9]  = '{1'b0, 1'b0, 6'd20, 8'h00, 8'h5A};
    tbl[10] = '{1'b1, 1'b0, 6'd15, 8'h00, 8'h4F};
    tbl[11] = '{1'b0, 1'b0, 6'd16, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 6'd0,  8'h00, 8'h40};

    // ---------------- reset state ----------------
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("rst");
    chk("rst_sramOe", 32'(sramOe), 32'd1);
    chk("rst_cpuRdy", 32'(cpuRdy), 32'd0);
    chk("rst_dmaAck", 32'(dmaAck), 32'd0);
    chk("rst_cpuQ", 32'(cpuQ), 32'd0);
    chk("rst_dmaQ", 32'(dmaQ), 32'd0);
    chk("rst_ub_lb", {30'd0, sramUb, sramLb}, 32'd2);

    // ---------------- fill with a CPU write pending ----------------
    cpuWr = 1'b1; cpuA = 6'd20; cpuD = 8'h5A;
    @(negedge clock) reset = 1'b1;
    wait_init(0, n, early);
    chk("fill_init", 32'(init), 32'd1);
    chk("fill_clocks", 32'(n), 32'd128);
    chk("no_rdy_in_fill", 32'(early), 32'd0);
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (cpuRdy !== 1'b1 && lat < 20);
    cpuWr = 1'b0;
    chk("pending_wr_lat", 32'(lat), 32'd3);
    @(posedge clock); #1;
    model_fill();
    exp_mem[20] = 8'h5A;
    for (int i = 0; i < DEPTH; i++) chk($sformatf("sram[%0d]", i), 32'(sram[i]), 32'(exp_mem[i]));

    // ---------------- table-driven accesses ----------------
    last_cpu_q = 8'h00;
    last_dma_q = 8'h00;
    for (int k = 0; k < 13; k++) begin
      do_access(tbl[k].dma, tbl[k].we, tbl[k].a, tbl[k].d, q, lat, wl);
      chk($sformatf("tbl%0d_lat", k), 32'(lat), 32'd3);
      chk($sformatf("tbl%0d_we_low", k), 32'(wl), tbl[k].we ? 32'd1 : 32'd0);
      if (tbl[k].we) begin
        exp_mem[tbl[k].a] = tbl[k].d;
      end else begin
        chk($sformatf("tbl%0d_q", k), 32'(q), 32'(tbl[k].exp_q));
        if (tbl[k].dma) last_dma_q = tbl[k].exp_q; else last_cpu_q = tbl[k].exp_q;
      end
      chk($sformatf("tbl%0d_cpuQ_hold", k), 32'(cpuQ), 32'(last_cpu_q));
      chk($sformatf("tbl%0d_dmaQ_hold", k), 32'(dmaQ), 32'(last_dma_q));
    end

    // ---------------- simultaneous CPU and DMA reads ----------------
    cpuRd = 1'b1; cpuA = 6'd12;
    dmaReq = 1'b1; dmaWe = 1'b0; dmaA = 6'd30;
    n = 0; t_c = -1; t_d = -1;
    while ((t_c < 0 || t_d < 0) && n < 30) begin
      @(posedge clock); #1;
      n++;
      if (cpuRdy === 1'b1) begin t_c = n; cpuRd = 1'b0; end
      if (dmaAck === 1'b1) begin t_d = n; dmaReq = 1'b0; end
    end
    cpuRd = 1'b0; dmaReq = 1'b0;
    chk("same_clk_cpu_t", 32'(t_c), 32'd3);
    chk("same_clk_dma_t", 32'(t_d), 32'd7);
    chk("same_clk_cpuQ", 32'(cpuQ), 32'(exp_mem[12]));
    chk("same_clk_dmaQ", 32'(dmaQ), 32'(exp_mem[30]));
    @(posedge clock); #1;

    // ---------------- starvation guard ----------------
    sc = 0;
    for (int k = 0; k < 6; k++) begin
      if (sc == STARVE) begin exp_ord[k] = 1'b1; sc = 0; end
      else begin exp_ord[k] = 1'b0; sc++; end
    end
    cpuRd = 1'b1; cpuA = 6'd1;
    dmaReq = 1'b1; dmaWe = 1'b0; dmaA = 6'd2;
    n = 0;
    while (got_ord.size() < 6 && n < 80) begin
      @(posedge clock); #1;
      n++;
      if (cpuRdy === 1'b1 && dmaAck === 1'b1) chk("both_pulses", 32'd1, 32'd0);
      if (cpuRdy === 1'b1) begin got_ord.push_back(1'b0); got_t.push_back(n); end
      else if (dmaAck === 1'b1) begin got_ord.push_back(1'b1); got_t.push_back(n); end
    end
    cpuRd = 1'b0; dmaReq = 1'b0;
    chk("starve_count", 32'(got_ord.size()), 32'd6);
    last_d = 0;
    for (int k = 0; k < got_ord.size(); k++) begin
      chk($sformatf("starve_grant%0d", k), 32'(got_ord[k]), 32'(exp_ord[k]));
      if (got_ord[k]) begin
        if (got_t[k] - last_d > 12) chk($sformatf("dma_gap%0d", k), 32'(got_t[k] - last_d), 32'd12);
        last_d = got_t[k];
      end
    end
    chk("dma_read_q", 32'(dmaQ), 32'(exp_mem[2]));
    chk("cpu_read_q", 32'(cpuQ), 32'(exp_mem[1]));
    @(posedge clock); #1;

    // ---------------- randomized accesses ----------------
    for (int k = 0; k < 40; k++) begin
      bit r_dma, r_we;
      logic [AW-1:0] r_a;
      logic [7:0] r_d;
      r_dma = 1'($urandom_range(0, 1));
      r_we  = 1'($urandom_range(0, 1));
      r_a   = 6'($urandom_range(0, DEPTH - 1));
      r_d   = 8'($urandom);
      do_access(r_dma, r_we, r_a, r_d, q, lat, wl);
      chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'd3);
      if (r_we) begin
        exp_mem[r_a] = r_d;
        chk($sformatf("rnd%0d_we_low", k), 32'(wl), 32'd1);
      end else begin
        chk($sformatf("rnd%0d_q", k), 32'(q), 32'(exp_mem[r_a]));
      end
    end

    // ---------------- reset during fill at counter 20 ----------------
    reset = 1'b0;
    #1;
    @(negedge clock) reset = 1'b1;
    repeat (41) @(posedge clock);
    #1;
    chk("fill20_addr", 32'(sramA), 32'd20);
    chk("fill20_we", 32'(sramWe), 32'd0);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_fill");
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    chk("refill_addr0", 32'(sramA), 32'd0);
    chk("refill_we0", 32'(sramWe), 32'd0);
    wait_init(1, n, early);
    chk("refill_clocks", 32'(n), 32'd128);
    model_fill();

    // ---------------- reset during STB of a write ----------------
    cpuWr = 1'b1; cpuA = 6'd9; cpuD = 8'h99;
    repeat (2) @(posedge clock);
    #1;
    chk("stb_we_low", 32'(sramWe), 32'd0);
    reset = 1'b0;
    #1;
    cpuWr = 1'b0;
    chk_reset_outputs("rst_stb");
    chk("rst_stb_cpuRdy", 32'(cpuRdy), 32'd0);
    @(negedge clock) reset = 1'b1;
    wait_init(0, n, early);
    chk("refill2_clocks", 32'(n), 32'd128);
    do_access(1'b0, 1'b0, 6'd9, 8'h00, q, lat, wl);
    chk("after_rst_read9", 32'(q), 32'(exp_mem[9]));
    do_access(1'b1, 1'b0, 6'd33, 8'h00, q, lat, wl);
    chk("after_rst_read33", 32'(q), 32'(exp_mem[33]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
